response_collector: RTL and testbench

- Requestor-side sink for the responder NoC. Pops response packets from the NoC egress FIFO and checks each one against a 64-entry outstanding-request scoreboard.
- Forwards accepted reply data to the local result register file.
- Closes the request/response loop that the responder stage opens: it tracks which reg_ids are in flight and flags misrouted, unexpected or duplicate traffic.

---
 rtl/response_collector_pkg.sv | 23 ++
 rtl/response_collector_if.sv | 44 ++++
 rtl/rc_scoreboard.sv | 65 ++++++
 rtl/response_collector.sv | 143 ++++++++++++++
 tb/tb_response_collector.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/response_collector_pkg.sv
// Shared definitions for the response collector and the responder stage.
// Holds the response packet field offsets (single source for both sides),
// the default widths and the collector FSM state encoding.
package response_collector_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_RID_W  = 6;

    // Response packet layout, LSB first: valid, dest, reg_id, data.
    localparam int unsigned VALID_BIT = 0;
    localparam int unsigned DEST_LSB  = 1;
    localparam int unsigned DEST_W    = 2;
    localparam int unsigned RID_LSB   = 3;
    localparam int unsigned DATA_LSB  = RID_LSB + DEFAULT_RID_W;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StCheck = 2'd2,
        StWrite = 2'd3
    } rc_state_e;

endpackage

// File: rtl/response_collector_if.sv
// Bus bundle between the response collector, the NoC egress FIFO and the
// local result register file.
//   empty    : FIFO empty
//   dataIn   : FIFO read data, valid one cycle after read
//   read     : FIFO pop strobe
//   wr_ready : register file can accept a write
//   wr_en    : result write strobe
//   wr_addr  : result address (reg_id)
//   wr_data  : reply data
// master = collector side, slave = FIFO / register file side.
interface response_collector_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RID_W  = 6
) ();
    localparam int unsigned RESP_W = DATA_W + RID_W + 3;

    logic              empty;
    logic [RESP_W-1:0] dataIn;
    logic              read;
    logic              wr_ready;
    logic              wr_en;
    logic [RID_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  empty,
        input  dataIn,
        output read,
        input  wr_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output empty,
        output dataIn,
        input  read,
        output wr_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/rc_scoreboard.sv
// Outstanding-request scoreboard: one bit per reg_id plus an in-flight count.
//   clk, reset     : clock, synchronous active-high reset
//   set_i/set_idx_i: issue of a new request (sets the bit if clear)
//   clr_i/clr_idx_i: accepted response (clears the bit)
//   hit_o          : current bit for clr_idx_i (used as the test port)
//   reissue_o      : registered 1-cycle pulse, issue to an already-set bit
//   outstanding_o  : registered count of set bits
//   all_done_o     : registered, outstanding == 0
module rc_scoreboard #(
    parameter int unsigned RID_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_i,
    input  logic [RID_W-1:0] set_idx_i,
    input  logic             clr_i,
    input  logic [RID_W-1:0] clr_idx_i,
    output logic             hit_o,
    output logic             reissue_o,
    output logic [RID_W:0]   outstanding_o,
    output logic             all_done_o
);
    localparam int unsigned Depth = 1 << RID_W;

    logic [Depth-1:0] bits_q, bits_d, after_clr;
    logic [RID_W:0]   cnt_q, cnt_d;
    logic             reissue_q, reissue_d;
    logic             all_done_q;
    logic             set_acc;

    always_comb begin
        // Clear is applied before set so a same-cycle clear/set of one
        // reg_id leaves the bit set with no reissue error.
        after_clr = bits_q;
        if (clr_i) begin
            after_clr[clr_idx_i] = 1'b0;
        end
        set_acc   = set_i && !after_clr[set_idx_i];
        reissue_d = set_i && after_clr[set_idx_i];
        bits_d    = after_clr;
        if (set_acc) begin
            bits_d[set_idx_i] = 1'b1;
        end
        cnt_d = cnt_q + {{RID_W{1'b0}}, set_acc} - {{RID_W{1'b0}}, clr_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q     <= '0;
            cnt_q      <= '0;
            reissue_q  <= 1'b0;
            all_done_q <= 1'b1;
        end else begin
            bits_q     <= bits_d;
            cnt_q      <= cnt_d;
            reissue_q  <= reissue_d;
            all_done_q <= (cnt_d == '0);
        end
    end

    assign hit_o         = bits_q[clr_idx_i];
    assign reissue_o     = reissue_q;
    assign outstanding_o = cnt_q;
    assign all_done_o    = all_done_q;
endmodule

// File: rtl/response_collector.sv
// Requestor-side sink for the responder NoC. Pops response packets from the
// egress FIFO, checks them against the outstanding-request scoreboard and
// forwards accepted reply data to the result register file.
//   clk, reset        : clock, synchronous active-high reset
//   my_id             : this node's port ID
//   rsp               : FIFO pop / register-file write bundle (master side)
//   issue_valid/_reg_id: locally issued request
//   outstanding       : in-flight request count
//   all_done          : outstanding == 0
//   err_misroute      : pulse, dest != my_id
//   err_unexpected    : pulse, response for a reg_id not outstanding
//   err_reissue       : pulse, issue to a reg_id already outstanding
module response_collector
    import response_collector_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned RID_W  = DEFAULT_RID_W,
    parameter int unsigned RESP_W = DATA_W + RID_W + 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DEST_W-1:0]    my_id,
    response_collector_if.master rsp,
    input  logic                 issue_valid,
    input  logic [RID_W-1:0]     issue_reg_id,
    output logic [RID_W:0]       outstanding,
    output logic                 all_done,
    output logic                 err_misroute,
    output logic                 err_unexpected,
    output logic                 err_reissue
);
    localparam int unsigned DataLsb = RID_LSB + RID_W;

    rc_state_e         state_q, state_d;
    logic [RESP_W-1:0] pkt_q, pkt_d;
    logic              wr_en_q, wr_en_d;
    logic [RID_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              err_misroute_q, err_misroute_d;
    logic              err_unexp_q, err_unexp_d;
    logic              fifo_read;
    logic              sb_clr, sb_hit;

    logic              pkt_valid;
    logic [DEST_W-1:0] pkt_dest;
    logic [RID_W-1:0]  pkt_rid;
    logic [DATA_W-1:0] pkt_data;

    assign pkt_valid = pkt_q[VALID_BIT];
    assign pkt_dest  = pkt_q[DEST_LSB +: DEST_W];
    assign pkt_rid   = pkt_q[RID_LSB +: RID_W];
    assign pkt_data  = pkt_q[DataLsb +: DATA_W];

    rc_scoreboard #(
        .RID_W (RID_W)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .set_i         (issue_valid),
        .set_idx_i     (issue_reg_id),
        .clr_i         (sb_clr),
        .clr_idx_i     (pkt_rid),
        .hit_o         (sb_hit),
        .reissue_o     (err_reissue),
        .outstanding_o (outstanding),
        .all_done_o    (all_done)
    );

    always_comb begin
        state_d        = state_q;
        pkt_d          = pkt_q;
        wr_en_d        = wr_en_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        err_misroute_d = 1'b0;
        err_unexp_d    = 1'b0;
        fifo_read      = 1'b0;
        sb_clr         = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated by reset so nothing is popped while reset is held.
                if (!rsp.empty && rsp.wr_ready && !reset) begin
                    fifo_read = 1'b1;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                pkt_d   = rsp.dataIn;
                state_d = StCheck;
            end
            StCheck: begin
                state_d = StIdle;
                if (!pkt_valid) begin
                    // Empty slot, dropped silently.
                end else if (pkt_dest != my_id) begin
                    err_misroute_d = 1'b1;
                end else if (!sb_hit) begin
                    err_unexp_d = 1'b1;
                end else begin
                    sb_clr    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = pkt_rid;
                    wr_data_d = pkt_data;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                if (rsp.wr_ready) begin
                    wr_en_d = 1'b0;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            pkt_q          <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            err_misroute_q <= 1'b0;
            err_unexp_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pkt_q          <= pkt_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            err_misroute_q <= err_misroute_d;
            err_unexp_q    <= err_unexp_d;
        end
    end

    assign rsp.read       = fifo_read;
    assign rsp.wr_en      = wr_en_q;
    assign rsp.wr_addr    = wr_addr_q;
    assign rsp.wr_data    = wr_data_q;
    assign err_misroute   = err_misroute_q;
    assign err_unexpected = err_unexp_q;
endmodule

// File: tb/tb_response_collector.sv
// Scoreboard bench for response_collector: the stimulus side pushes expected
// writes/errors into queues from a reg_id-set reference model; a monitor pops
// and compares whenever the DUT writes or pulses an error.
module tb_response_collector;
    localparam int unsigned DW = 16;
    localparam int unsigned RW = 6;
    localparam int unsigned PW = DW + RW + 3;
    localparam logic [1:0] MY_ID = 2'd2;

    typedef struct {
        int            kind;  // 0 write, 1 misroute, 2 unexpected
        logic [RW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    my_id;
    logic          issue_valid;
    logic [RW-1:0] issue_reg_id;
    logic [RW:0]   outstanding;
    logic          all_done, err_misroute, err_unexpected, err_reissue;

    response_collector_if #(.DATA_W(DW), .RID_W(RW)) bus ();

    response_collector #(.DATA_W(DW), .RID_W(RW)) dut (
        .clk            (clk),
        .reset          (reset),
        .my_id          (my_id),
        .rsp            (bus),
        .issue_valid    (issue_valid),
        .issue_reg_id   (issue_reg_id),
        .outstanding    (outstanding),
        .all_done       (all_done),
        .err_misroute   (err_misroute),
        .err_unexpected (err_unexpected),
        .err_reissue    (err_reissue)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    int          wr_cnt = 0;
    bit          toggle_en = 1'b0;
    bit          sb_m [64];
    ev_t         evq [$];
    int          rsq [$];
    logic [PW-1:0] fifo [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (sb_m[i]) n += int'(sb_m[i]);
        return n;
    endfunction

    task automatic do_issue(input int rid);
        issue_valid  = 1'b1;
        issue_reg_id = RW'(rid);
        if (sb_m[rid]) rsq.push_back(rid);
        else sb_m[rid] = 1'b1;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic send_pkt(input bit v, input logic [1:0] d, input int rid,
                            input logic [DW-1:0] data);
        ev_t e;
        e.kind = 0;
        e.addr = '0;
        e.data = '0;
        if (v) begin
            if (d != MY_ID) begin
                e.kind = 1;
                evq.push_back(e);
            end else if (!sb_m[rid]) begin
                e.kind = 2;
                evq.push_back(e);
            end else begin
                sb_m[rid] = 1'b0;
                e.addr = RW'(rid);
                e.data = data;
                evq.push_back(e);
            end
        end
        fifo.push_back({data, RW'(rid), d, v});
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((fifo.size() != 0 || evq.size() != 0 || rsq.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (fifo.size() != 0 || evq.size() != 0 || rsq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: fifo=%0d events=%0d reissues=%0d left, expected 0",
                     fifo.size(), evq.size(), rsq.size());
        end
        repeat (6) tick();
    endtask

    task automatic wait_pop(input int p0);
        int n = 0;
        while (pops == p0 && n < 100) begin
            tick();
            n++;
        end
        check("pop_timeout", 64'(pops - p0), 64'd1);
    endtask

    task automatic pop_expect(input int kind, input logic [RW-1:0] a, input logic [DW-1:0] d);
        ev_t e;
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("FAIL event: got kind=%0d addr=%0d data=%h, expected none", kind, a, d);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || (kind == 0 && (e.addr !== a || e.data !== d))) begin
                errors++;
                $display("FAIL event: got kind=%0d addr=%0d data=%h, expected kind=%0d addr=%0d data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    // FIFO model: pop on read, data presented for the FETCH cycle.
    initial begin
        bit gate;
        bus.empty  = 1'b1;
        bus.dataIn = '0;
        forever begin
            @(negedge clk);
            if (bus.read === 1'b1) begin
                checks++;
                if (bus.empty !== 1'b0 || fifo.size() == 0) begin
                    errors++;
                    $display("FAIL read_while_empty: got read=1 empty=%0b, expected no read", bus.empty);
                end else begin
                    bus.dataIn = fifo.pop_front();
                    pops++;
                end
            end
            @(posedge clk);
            #1;
            gate = toggle_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.empty = (fifo.size() == 0) || gate;
        end
    end

    // Monitor: pops expected events whenever the DUT presents one.
    initial begin
        bit            prev_stall = 1'b0;
        logic [RW-1:0] prev_addr = '0;
        logic [DW-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                checks++;
                if (bus.read !== 1'b0) begin
                    errors++;
                    $display("FAIL read_in_reset: got read=%0b, expected 0", bus.read);
                end
                prev_stall = 1'b0;
            end else begin
                if (bus.wr_en === 1'b1) begin
                    checks++;
                    if (bus.read !== 1'b0) begin
                        errors++;
                        $display("FAIL read_during_write: got read=%0b, expected 0", bus.read);
                    end
                end
                if (prev_stall) begin
                    checks++;
                    if (bus.wr_en !== 1'b1 || bus.wr_addr !== prev_addr || bus.wr_data !== prev_data) begin
                        errors++;
                        $display("FAIL write_hold: got en=%0b addr=%0d data=%h, expected en=1 addr=%0d data=%h",
                                 bus.wr_en, bus.wr_addr, bus.wr_data, prev_addr, prev_data);
                    end
                end
                if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
                    wr_cnt++;
                    pop_expect(0, bus.wr_addr, bus.wr_data);
                end
                if (err_misroute === 1'b1) pop_expect(1, '0, '0);
                if (err_unexpected === 1'b1) pop_expect(2, '0, '0);
                if (err_reissue === 1'b1) begin
                    checks++;
                    if (rsq.size() == 0) begin
                        errors++;
                        $display("FAIL reissue: got err_reissue=1, expected 0");
                    end else begin
                        void'(rsq.pop_front());
                    end
                end
                prev_stall = (bus.wr_en === 1'b1) && (bus.wr_ready === 1'b0);
                prev_addr  = bus.wr_addr;
                prev_data  = bus.wr_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int perm [64];
        int p0, w0, n, tmp, j;
        reset        = 1'b1;
        my_id        = MY_ID;
        issue_valid  = 1'b0;
        issue_reg_id = '0;
        bus.wr_ready = 1'b1;
        repeat (3) tick();

        check("rst_read", 64'(bus.read), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_wr_data", 64'(bus.wr_data), 64'd0);
        check("rst_err_misroute", 64'(err_misroute), 64'd0);
        check("rst_err_unexpected", 64'(err_unexpected), 64'd0);
        check("rst_err_reissue", 64'(err_reissue), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_all_done", 64'(all_done), 64'd1);
        reset = 1'b0;
        tick();

        // Basic accepted response.
        do_issue(5);
        check("t1_outstanding_1", 64'(outstanding), 64'd1);
        check("t1_all_done_0", 64'(all_done), 64'd0);
        p0 = pops;
        w0 = wr_cnt;
        send_pkt(1'b1, MY_ID, 5, 16'hBEEF);
        wait_idle(100);
        check("t1_one_read", 64'(pops - p0), 64'd1);
        check("t1_one_write", 64'(wr_cnt - w0), 64'd1);
        check("t1_outstanding_0", 64'(outstanding), 64'd0);
        check("t1_all_done_1", 64'(all_done), 64'd1);

        // Misroute while reg_id 5 outstanding.
        do_issue(5);
        w0 = wr_cnt;
        send_pkt(1'b1, 2'd1, 5, 16'h1234);
        wait_idle(100);
        check("t2_no_write", 64'(wr_cnt - w0), 64'd0);
        check("t2_outstanding", 64'(outstanding), 64'd1);

        // Unexpected reg_id, then an invalid slot.
        send_pkt(1'b1, MY_ID, 9, 16'h0909);
        wait_idle(100);
        send_pkt(1'b0, MY_ID, 5, 16'h5555);
        wait_idle(100);
        check("t3_no_write", 64'(wr_cnt - w0), 64'd0);
        check("t3_outstanding", 64'(outstanding), 64'd1);
        send_pkt(1'b1, MY_ID, 5, 16'h0005);
        wait_idle(100);

        // Reissue, then issue in the same cycle as the accepting CHECK.
        do_issue(3);
        do_issue(3);
        wait_idle(100);
        check("t4_outstanding_reissue", 64'(outstanding), 64'd1);
        p0 = pops;
        send_pkt(1'b1, MY_ID, 3, 16'h3333);
        wait_pop(p0);
        tick();
        issue_valid  = 1'b1;
        issue_reg_id = 6'd3;
        if (sb_m[3]) rsq.push_back(3);
        else sb_m[3] = 1'b1;
        tick();
        issue_valid = 1'b0;
        wait_idle(100);
        check("t4_same_cycle_outstanding", 64'(outstanding), 64'(model_count()));
        check("t4_same_cycle_count_1", 64'(outstanding), 64'd1);

        // Write stall with a second packet waiting.
        do_issue(10);
        do_issue(11);
        wait_idle(100);
        p0 = pops;
        send_pkt(1'b1, MY_ID, 10, 16'hAAAA);
        send_pkt(1'b1, MY_ID, 11, 16'hBBBB);
        n = 0;
        while (bus.wr_en !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("t5_wr_en_seen", 64'(bus.wr_en), 64'd1);
        bus.wr_ready = 1'b0;
        repeat (5) tick();
        check("t5_stall_wr_en", 64'(bus.wr_en), 64'd1);
        check("t5_stall_addr", 64'(bus.wr_addr), 64'd10);
        check("t5_stall_data", 64'(bus.wr_data), 64'hAAAA);
        check("t5_second_not_popped", 64'(pops - p0), 64'd1);
        bus.wr_ready = 1'b1;
        wait_idle(100);
        check("t5_both_popped", 64'(pops - p0), 64'd2);
        check("t5_outstanding", 64'(outstanding), 64'(model_count()));

        // 64 distinct issues, responses in reverse order with empty toggling.
        foreach (sb_m[i]) begin
            if (sb_m[i]) send_pkt(1'b1, MY_ID, i, 16'h0);
        end
        wait_idle(200);
        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 64; i++) do_issue(perm[i]);
        wait_idle(50);
        check("t6_outstanding_64", 64'(outstanding), 64'd64);
        check("t6_all_done_0", 64'(all_done), 64'd0);
        w0 = wr_cnt;
        toggle_en = 1'b1;
        for (int i = 63; i >= 0; i--) send_pkt(1'b1, MY_ID, perm[i], 16'($urandom));
        wait_idle(4000);
        toggle_en = 1'b0;
        check("t6_writes_64", 64'(wr_cnt - w0), 64'd64);
        check("t6_outstanding_0", 64'(outstanding), 64'd0);
        check("t6_all_done_1", 64'(all_done), 64'd1);

        // Randomised mix against the reference model.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_issue(int'($urandom_range(0, 15)));
            end else begin
                send_pkt(($urandom_range(0, 7) != 0),
                         ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : MY_ID,
                         int'($urandom_range(0, 15)), 16'($urandom));
            end
            wait_idle(100);
            check("rand_outstanding", 64'(outstanding), 64'(model_count()));
            check("rand_all_done", 64'(all_done), 64'(model_count() == 0));
        end

        // Reset applied during FETCH: in-flight packet discarded.
        do_issue(20);
        do_issue(21);
        wait_idle(50);
        p0 = pops;
        send_pkt(1'b1, MY_ID, 20, 16'h2020);
        wait_pop(p0);
        reset = 1'b1;
        foreach (sb_m[i]) sb_m[i] = 1'b0;
        evq.delete();
        rsq.delete();
        p0 = pops;
        send_pkt(1'b1, MY_ID, 21, 16'h2121);
        tick();
        tick();
        check("t7_no_pop_in_reset", 64'(pops - p0), 64'd0);
        check("t7_outstanding_0", 64'(outstanding), 64'd0);
        check("t7_all_done_1", 64'(all_done), 64'd1);
        check("t7_wr_en_0", 64'(bus.wr_en), 64'd0);
        reset = 1'b0;
        w0 = wr_cnt;
        wait_idle(100);
        check("t7_post_reset_no_write", 64'(wr_cnt - w0), 64'd0);
        do_issue(7);
        send_pkt(1'b1, MY_ID, 7, 16'h7777);
        wait_idle(100);
        check("t7_post_reset_write", 64'(wr_cnt - w0), 64'd1);
        check("t7_final_outstanding", 64'(outstanding), 64'd0);

        check("final_events_left", 64'(evq.size()), 64'd0);
        check("final_reissues_left", 64'(rsq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
